// File: rtl/inert_sample_seq_pkg.sv
// Shared types and constants for the IMU access sequencer: FSM state
// encoding, the eight SPI command words and the power-up wait width.
package inert_pkg;

  localparam int INIT_WAIT_W_DEF = 16;

  // IMU configuration writes, issued once after the power-up wait
  localparam logic [15:0] CMD_INIT1 = 16'h0D02; // INT pin on data-ready
  localparam logic [15:0] CMD_INIT2 = 16'h1053; // accel output data rate
  localparam logic [15:0] CMD_INIT3 = 16'h1150; // gyro output data rate
  localparam logic [15:0] CMD_INIT4 = 16'h1460; // rounding

  // Byte reads performed on every data-ready interrupt
  localparam logic [15:0] CMD_RD_PL = 16'hA200; // pitch rate low
  localparam logic [15:0] CMD_RD_PH = 16'hA300; // pitch rate high
  localparam logic [15:0] CMD_RD_AL = 16'hAC00; // accel Z low
  localparam logic [15:0] CMD_RD_AH = 16'hAD00; // accel Z high

  typedef enum logic [3:0] {
    ST_WAIT  = 4'd0,
    ST_INIT1 = 4'd1,
    ST_INIT2 = 4'd2,
    ST_INIT3 = 4'd3,
    ST_INIT4 = 4'd4,
    ST_IDLE  = 4'd5,
    ST_RD_PL = 4'd6,
    ST_RD_PH = 4'd7,
    ST_RD_AL = 4'd8,
    ST_RD_AH = 4'd9,
    ST_VLD   = 4'd10
  } state_t;

  // True for every state that owns one SPI transaction
  function automatic logic is_xfer(input state_t s);
    logic r;
    case (s)
      ST_INIT1, ST_INIT2, ST_INIT3, ST_INIT4,
      ST_RD_PL, ST_RD_PH, ST_RD_AL, ST_RD_AH: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // Command word belonging to a transaction state
  function automatic logic [15:0] cmd_of(input state_t s);
    logic [15:0] c;
    case (s)
      ST_INIT1: c = CMD_INIT1;
      ST_INIT2: c = CMD_INIT2;
      ST_INIT3: c = CMD_INIT3;
      ST_INIT4: c = CMD_INIT4;
      ST_RD_PL: c = CMD_RD_PL;
      ST_RD_PH: c = CMD_RD_PH;
      ST_RD_AL: c = CMD_RD_AL;
      ST_RD_AH: c = CMD_RD_AH;
      default:  c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/inert_sample_seq_int_sync.sv
// Brings the asynchronous IMU interrupt into the clk domain through two
// flops and produces a single-cycle pulse on each synchronized rising edge.
// A level held high yields exactly one pulse.
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Two-stage synchronizer followed by the edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/inert_sample_seq.sv
// IMU access sequencer for the pitch datapath. After a power-up wait it
// writes four configuration commands over the SPI master, then on every
// data-ready interrupt reads pitch rate and accel Z one byte at a time and
// presents both 16-bit samples together with a one-cycle vld strobe.
//
// SPI handshake: spi_wrt is a one-cycle request issued on entry to a
// transaction state, with spi_cmd loaded in the same cycle and held until
// completion. spi_done is a one-cycle completion pulse with spi_rd valid in
// that cycle; a spi_done coinciding with spi_wrt belongs to no transaction
// of ours and is ignored.
module inert_sample_seq
  import inert_pkg::*;
#(
  parameter int INIT_WAIT_W = INIT_WAIT_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_done,
  output state_t      dbg_state_o
);

  localparam logic [INIT_WAIT_W-1:0] CNT_ONE = {{(INIT_WAIT_W-1){1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [INIT_WAIT_W-1:0] cnt_q, cnt_d;

  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [7:0]  pl_q, pl_d;
  logic [7:0]  ph_q, ph_d;
  logic [7:0]  al_q, al_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] az_q, az_d;
  logic        vld_q, vld_d;
  logic        init_done_q, init_done_d;

  logic int_pulse;
  logic done_ok;
  logic unused_rd_hi;

  int_sync u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (INT),
    .pulse_o (int_pulse)
  );

  // Only the low byte of a read result carries register data
  assign unused_rd_hi = ^spi_rd[15:8];

  // A completion in the request cycle is not ours
  assign done_ok = spi_done & ~wrt_q;

  // State register and saturating power-up wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: wait, configure, then read on each interrupt edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '1) state_d = ST_INIT1;
        else             cnt_d   = cnt_q + CNT_ONE;
      end
      ST_INIT1: if (done_ok) state_d = ST_INIT2;
      ST_INIT2: if (done_ok) state_d = ST_INIT3;
      ST_INIT3: if (done_ok) state_d = ST_INIT4;
      ST_INIT4: if (done_ok) state_d = ST_IDLE;
      ST_IDLE:  if (int_pulse) state_d = ST_RD_PL;
      ST_RD_PL: if (done_ok) state_d = ST_RD_PH;
      ST_RD_PH: if (done_ok) state_d = ST_RD_AL;
      ST_RD_AL: if (done_ok) state_d = ST_RD_AH;
      ST_RD_AH: if (done_ok) state_d = ST_VLD;
      ST_VLD:   state_d = ST_IDLE;
      default:  state_d = ST_WAIT;
    endcase
  end

  // Output/next-value logic: request on state entry, byte capture on done,
  // and a single coherent update of both samples when the last byte lands
  always_comb begin
    wrt_d       = is_xfer(state_d) && (state_d != state_q);
    cmd_d       = wrt_d ? cmd_of(state_d) : cmd_q;
    pl_d        = pl_q;
    ph_d        = ph_q;
    al_d        = al_q;
    ptch_d      = ptch_q;
    az_d        = az_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    if (done_ok) begin
      case (state_q)
        ST_INIT4: init_done_d = 1'b1;
        ST_RD_PL: pl_d = spi_rd[7:0];
        ST_RD_PH: ph_d = spi_rd[7:0];
        ST_RD_AL: al_d = spi_rd[7:0];
        ST_RD_AH: begin
          ptch_d = {ph_q, pl_q};
          az_d   = {spi_rd[7:0], al_q};
          vld_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_q       <= 1'b0;
      cmd_q       <= 16'h0000;
      pl_q        <= 8'h00;
      ph_q        <= 8'h00;
      al_q        <= 8'h00;
      ptch_q      <= 16'h0000;
      az_q        <= 16'h0000;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      wrt_q       <= wrt_d;
      cmd_q       <= cmd_d;
      pl_q        <= pl_d;
      ph_q        <= ph_d;
      al_q        <= al_d;
      ptch_q      <= ptch_d;
      az_q        <= az_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi_wrt     = wrt_q;
  assign spi_cmd     = cmd_q;
  assign ptch_rt     = ptch_q;
  assign AZ          = az_q;
  assign vld         = vld_q;
  assign init_done   = init_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_inert_sample_seq.sv
// Bench for the IMU access sequencer: an SPI slave model with configurable
// latency, an expected-command queue, an expected-sample queue and a
// per-cycle check of vld, init_done and output stability.
module tb_inert_sample_seq;
  import inert_pkg::*;

  localparam int W        = 4;
  localparam int WAIT_CYC = (1 << W) - 1;

  logic        clk;
  logic        rst_n;
  logic        INT;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;
  logic        init_done;
  state_t      dbg_state;

  inert_sample_seq #(.INIT_WAIT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .INT         (INT),
    .spi_wrt     (spi_wrt),
    .spi_cmd     (spi_cmd),
    .spi_done    (spi_done),
    .spi_rd      (spi_rd),
    .ptch_rt     (ptch_rt),
    .AZ          (AZ),
    .vld         (vld),
    .init_done   (init_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];   // expected spi_cmd words, in order
  logic [31:0] exp_s[$];   // expected {ptch_rt, AZ} samples, in order
  logic [7:0]  rb[4];      // bytes the slave returns for PL, PH, AL, AH
  int          checks = 0;
  int          errors = 0;

  bit          busy, early_en, vld_pend, init_pend, exp_init_done, prev_wrt, exp_vld;
  int          cnt, lat_lo, lat_hi, cyc_since_rst, first_wrt_cyc;
  logic [15:0] cur_cmd, cur_pt, cur_az;
  logic [31:0] smp;
  logic [7:0]  hb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] byte_for(input logic [15:0] c);
    case (c)
      16'hA200: return rb[0];
      16'hA300: return rb[1];
      16'hAC00: return rb[2];
      16'hAD00: return rb[3];
      default:  return 8'h77;
    endcase
  endfunction

  // ---------------- SPI slave model + per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; spi_done = 0; vld_pend = 0; init_pend = 0; exp_init_done = 0;
      prev_wrt = 0; cur_pt = 16'h0; cur_az = 16'h0; cyc_since_rst = 0; first_wrt_cyc = -1;
    end else begin
      cyc_since_rst++;
      exp_vld = vld_pend;
      vld_pend = 0;
      if (init_pend) exp_init_done = 1;
      init_pend = 0;
      chk("vld", {31'd0, vld}, {31'd0, exp_vld});
      chk("init_done", {31'd0, init_done}, {31'd0, exp_init_done});
      if (vld) begin
        if (exp_s.size() == 0) chk("vld_unexpected", 32'd1, 32'd0);
        else begin
          smp = exp_s.pop_front();
          chk("ptch_rt", {16'd0, ptch_rt}, {16'd0, smp[31:16]});
          chk("AZ", {16'd0, AZ}, {16'd0, smp[15:0]});
          cur_pt = smp[31:16];
          cur_az = smp[15:0];
        end
      end else begin
        chk("ptch_rt_hold", {16'd0, ptch_rt}, {16'd0, cur_pt});
        chk("AZ_hold", {16'd0, AZ}, {16'd0, cur_az});
      end
      spi_done = 0;
      if (spi_wrt) begin
        if (first_wrt_cyc < 0) first_wrt_cyc = cyc_since_rst;
        chk("wrt_one_cycle", {31'd0, prev_wrt}, 32'd0);
        chk("wrt_while_busy", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) chk("wrt_unexpected", {16'd0, spi_cmd}, 32'hFFFF_FFFF);
        else chk("spi_cmd", {16'd0, spi_cmd}, {16'd0, exp_q.pop_front()});
        busy = 1;
        cur_cmd = spi_cmd;
        cnt = $urandom_range(lat_hi, lat_lo);
        if (early_en) begin
          hb = 8'($urandom_range(255, 0));
          spi_done = 1;
          spi_rd = {hb, 8'h5A};
        end
      end else if (busy) begin
        chk("cmd_hold", {16'd0, spi_cmd}, {16'd0, cur_cmd});
        cnt--;
        if (cnt <= 0) begin
          hb = 8'($urandom_range(255, 0));
          spi_done = 1;
          spi_rd = {hb, byte_for(cur_cmd)};
          busy = 0;
          if (cur_cmd == 16'hAD00) vld_pend = 1;
          if (cur_cmd == 16'h1460) init_pend = 1;
        end
      end
      prev_wrt = spi_wrt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_all_zero(input string tag);
    chk({tag, "_spi_wrt"}, {31'd0, spi_wrt}, 32'd0);
    chk({tag, "_spi_cmd"}, {16'd0, spi_cmd}, 32'd0);
    chk({tag, "_ptch_rt"}, {16'd0, ptch_rt}, 32'd0);
    chk({tag, "_AZ"}, {16'd0, AZ}, 32'd0);
    chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
    chk({tag, "_init_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_WAIT));
  endtask

  // Asserts reset at the current time, checks the async clear, releases
  // and queues the configuration writes that must follow.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    INT = 1'b0;
    #1;
    chk_all_zero(tag);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_s.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    exp_q.push_back(16'h0D02);
    exp_q.push_back(16'h1053);
    exp_q.push_back(16'h1150);
    exp_q.push_back(16'h1460);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_s.size() != 0 || busy || vld_pend || init_pend) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 32'd1, 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic read_expect(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3;
    exp_q.push_back(16'hA200);
    exp_q.push_back(16'hA300);
    exp_q.push_back(16'hAC00);
    exp_q.push_back(16'hAD00);
    exp_s.push_back({b1, b0, b3, b2});
  endtask

  task automatic int_pulse(input int width);
    @(posedge clk);
    #1 INT = 1'b1;
    repeat (width) @(posedge clk);
    #1 INT = 1'b0;
  endtask

  task automatic wait_cmd(input logic [15:0] c, input string tag);
    int n;
    n = 0;
    while (!(busy && cur_cmd == c) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b1; INT = 1'b0; spi_done = 1'b0; spi_rd = 16'h0;
    lat_lo = 8; lat_hi = 8; early_en = 0;
    rb[0] = 8'h0; rb[1] = 8'h0; rb[2] = 8'h0; rb[3] = 8'h0;
    #2;

    // Power-up wait then the four configuration writes
    do_reset("rst");
    wait_idle("init", 300);
    chk("wait_window", {31'd0, (first_wrt_cyc >= WAIT_CYC && first_wrt_cyc <= WAIT_CYC + 2)}, 32'd1);
    chk("init_done_lit", {31'd0, init_done}, 32'd1);

    // Interrupt to first read request latency, then positive sample
    read_expect(8'h34, 8'h12, 8'hCD, 8'hAB);
    @(posedge clk);
    #1 INT = 1'b1;
    n = 0;
    while (!spi_wrt && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("int_latency", n, 32'd3);
    INT = 1'b0;
    wait_idle("rd1", 300);
    chk("ptch_lit1", {16'd0, ptch_rt}, 32'h1234);
    chk("AZ_lit1", {16'd0, AZ}, 32'hABCD);

    // Negative sample, held until the next vld
    read_expect(8'hB0, 8'hFF, 8'h60, 8'hFF);
    int_pulse(2);
    wait_idle("rd2", 300);
    repeat (10) @(posedge clk);
    chk("ptch_lit2", {16'd0, ptch_rt}, 32'hFFB0);
    chk("AZ_lit2", {16'd0, AZ}, 32'hFF60);

    // Edge during a read is dropped; a held level does not retrigger
    read_expect(8'h11, 8'h22, 8'h33, 8'h44);
    int_pulse(1);
    wait_cmd(16'hA300, "rd_ph");
    #1 INT = 1'b1;
    wait_idle("rd3", 300);
    repeat (20) @(posedge clk);
    chk("ptch_lit3", {16'd0, ptch_rt}, 32'h2211);
    chk("no_retrigger_q", exp_q.size(), 32'd0);
    #1 INT = 1'b0;
    repeat (4) @(posedge clk);
    read_expect(8'h55, 8'h66, 8'h77, 8'h88);
    #1 INT = 1'b1;
    wait_idle("rd4", 300);
    #1 INT = 1'b0;
    chk("AZ_lit4", {16'd0, AZ}, 32'h8877);

    // Spurious done in the request cycle must be ignored
    early_en = 1;
    lat_lo = 3; lat_hi = 3;
    read_expect(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    int_pulse(1);
    wait_idle("early", 300);
    chk("ptch_lit5", {16'd0, ptch_rt}, 32'hBEEF);
    chk("AZ_lit5", {16'd0, AZ}, 32'hDEAD);
    early_en = 0;

    // Reset in the middle of RD_AL, then full init replay
    lat_lo = 8; lat_hi = 8;
    read_expect(8'h01, 8'h02, 8'h03, 8'h04);
    int_pulse(1);
    wait_cmd(16'hAC00, "rd_al");
    #3;
    do_reset("midrst");
    wait_idle("reinit", 300);
    chk("rewait_window", {31'd0, (first_wrt_cyc >= WAIT_CYC && first_wrt_cyc <= WAIT_CYC + 2)}, 32'd1);
    chk("reinit_done", {31'd0, init_done}, 32'd1);

    // Randomized reads with varied latency, early dones and pulse widths
    lat_lo = 1; lat_hi = 6;
    for (int i = 0; i < 20; i++) begin
      early_en = ($urandom_range(1, 0) == 1);
      read_expect(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                  8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
      int_pulse($urandom_range(4, 1));
      wait_idle("rand", 300);
      repeat ($urandom_range(6, 2)) @(posedge clk);
    end
    early_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
